demux_route_ctrl: RTL
=====================

Name: demux_route_ctrl

Overview:
- Sequential front-end that drives a 1x4 demux (in, sel0, sel1) from an addressed valid/ready input stream.
- Sequences each transfer as setup, drive and guard phases, so the demux select lines never change while its data input is high. This rules out glitch pulses on a non-target output.
- Counts completed transfers per output channel.
- Sits directly upstream of the 1x4 demux; its registered outputs connect 1:1 to the demux inputs.

Parameters:
- HOLD_CYCLES, 2: number of cycles dmx_in carries the data bit per transfer; legal range is >=1 (elaboration error if 0).
- CNT_W, 8: width of each per-channel saturating transfer counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream transfer request.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  1  bit to route.
- in_dest  in  2  destination channel 0..3; bit1 drives sel1, bit0 drives sel0.
- cnt_clr  in  1  synchronous clear of all channel counters.
- sel0  out  1  demux select LSB, registered.
- sel1  out  1  demux select MSB, registered.
- dmx_in  out  1  demux data input, registered.
- busy  out  1  high in any state other than IDLE.
- ch_cnt  out  4*CNT_W  per-channel completed-transfer counts; channel k occupies bits [k*CNT_W +: CNT_W].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - sel0=sel1=0, dmx_in=0, busy=0, in_ready=1.
  - ch_cnt=0, internal hold counter=0.
  - dmx_in drops immediately, even in the middle of a transfer; the in-flight transfer is discarded and not counted.
- States: IDLE -> SETUP -> DRIVE -> GUARD -> IDLE.
- IDLE:
  - in_ready=1, dmx_in=0.
  - sel0/sel1 hold their last value (not returned to 0).
  - On in_valid&&in_ready at an edge: latch in_data and in_dest, load sel1:sel0=in_dest, go to SETUP.
- SETUP (1 cycle): sel holds the new destination, dmx_in=0, then go to DRIVE.
- DRIVE (HOLD_CYCLES cycles):
  - dmx_in=latched data; sel stable.
  - The hold counter counts from HOLD_CYCLES-1 down to 0; at 0, go to GUARD and increment ch_cnt[dest].
- GUARD (1 cycle): dmx_in=0, sel stable, then go to IDLE.
- Timing:
  - Accept edge E: SETUP visible after E.
  - dmx_in valid after edges E+1 .. E+HOLD_CYCLES.
  - in_ready high again after edge E+HOLD_CYCLES+2.
  - Peak throughput: one transfer per HOLD_CYCLES+3 cycles.
- in_data=0 is still a full transfer: dmx_in stays 0 through DRIVE, and the counter still increments.
- in_valid/in_data/in_dest are ignored outside IDLE; upstream must hold them until in_ready is sampled high.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr clears all four next edge.
  - If cnt_clr and an increment coincide, clear wins and the result is 0.
- Invariant: sel0/sel1 change only on the IDLE->SETUP edge; dmx_in=1 only in DRIVE.

Decomposition:
- Shared package demux_pkg:
  - state enum (IDLE, SETUP, DRIVE, GUARD).
  - NUM_CH=4.
  - SEL_W=2.
- One natural sub-module, sat_counter (parameter CNT_W; ports clk, rst_n, inc, clr, count), instantiated 4x.

Test Plan:
- Reset mid-DRIVE: accept dest=2 data=1, drop rst_n while dmx_in=1 -> dmx_in, sel0, sel1 = 0 immediately; ch_cnt all 0; in_ready=1.
- Single transfer, HOLD_CYCLES=2: dest=3 data=1 at edge E -> after E sel1=1 sel0=1 dmx_in=0; dmx_in=1 after E+1 and E+2; 0 after E+3; in_ready=1 after E+4; ch_cnt[3]=1.
- All four destinations back-to-back, data=1, in_valid held high:
  - Each accepted 5 cycles apart; sel sequence 00,01,10,11.
  - A bench monitor sees no cycle with dmx_in=1 while sel differs from the accepted dest.
  - Each ch_cnt[k]=1.
- data=0 to dest=1 -> dmx_in stays 0 for the whole transfer, ch_cnt[1]=1, busy high for 4 cycles.
- Saturation, CNT_W=2: 5 transfers to dest 0 -> ch_cnt[0]=3 after the 3rd transfer and remains 3.
- Clear collision: assert cnt_clr on the final DRIVE edge of a dest=2 transfer with ch_cnt[2]=5 -> ch_cnt[2]=0 next cycle; the following transfer makes it 1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the demux routing front-end.
package demux_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   // Transfer sequencing: select settles in SETUP, data only in DRIVE.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRIVE = 2'd2,
      GUARD = 2'd3
   } state_e;

endpackage : demux_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   // Count completed transfers, sticking at all-ones instead of wrapping.
   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/demux_route_ctrl.sv
// Glitch-free 1x4 demux driver: select lines move only while dmx_in is low,
// data is held for HOLD_CYCLES, and completed transfers are counted per channel.
module demux_route_ctrl
   import demux_pkg::*;
#(
   parameter int HOLD_CYCLES = 2,
   parameter int CNT_W       = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_data,
   input  logic [SEL_W-1:0]        in_dest,
   input  logic                    cnt_clr,
   output logic                    sel0,
   output logic                    sel1,
   output logic                    dmx_in,
   output logic                    busy,
   output logic [NUM_CH*CNT_W-1:0] ch_cnt
);

   if (HOLD_CYCLES < 1) begin : g_hold_chk
      $error("demux_route_ctrl: HOLD_CYCLES must be >= 1");
   end

   localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   state_e            state_q;
   logic [SEL_W-1:0]  sel_q;
   logic              data_q;
   logic              dmx_in_q;
   logic              busy_q;
   logic              in_ready_q;
   logic [HOLD_W-1:0] hold_q;

   logic              drive_done;
   logic [NUM_CH-1:0] inc_d;

   // Transfer sequencer; every output is a flop so the demux sees clean edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         data_q     <= 1'b0;
         dmx_in_q   <= 1'b0;
         busy_q     <= 1'b0;
         in_ready_q <= 1'b1;
         hold_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // sel_q keeps the previous destination while idle.
               if (in_valid && in_ready_q) begin
                  state_q    <= SETUP;
                  sel_q      <= in_dest;
                  data_q     <= in_data;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b0;
               end
            end
            SETUP: begin
               state_q  <= DRIVE;
               dmx_in_q <= data_q;
               hold_q   <= HOLD_LAST;
            end
            DRIVE: begin
               if (hold_q == '0) begin
                  state_q  <= GUARD;
                  dmx_in_q <= 1'b0;
               end else begin
                  hold_q <= hold_q - 1'b1;
               end
            end
            GUARD: begin
               state_q    <= IDLE;
               busy_q     <= 1'b0;
               in_ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign drive_done = (state_q == DRIVE) && (hold_q == '0);

   // One-hot increment for the channel whose transfer completes this edge.
   // NOTE: the default assignment first keeps this block purely combinational (no latch).
   always_comb begin
      inc_d = '0;
      if (drive_done) begin
         inc_d[sel_q] = 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
      sat_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (inc_d[k]),
         .clr   (cnt_clr),
         .count (ch_cnt[k*CNT_W +: CNT_W])
      );
   end

   assign sel0     = sel_q[0];
   assign sel1     = sel_q[1];
   assign dmx_in   = dmx_in_q;
   assign busy     = busy_q;
   assign in_ready = in_ready_q;

endmodule : demux_route_ctrl
